channel_switch_ctrl: RTL
========================

Name: channel_switch_ctrl

Overview:
- Sequencing controller for the single-ended/differential IQ channel crossbar between the mother-board and daughter-board IQ paths.
- Accepts tx/rx switch-code requests over a valid/ready handshake and rejects illegal combinations.
- Applies a legal route change only at a frame boundary (iqdata_fp), and mutes the datapath for a fixed settle window around the change.
- Drives the crossbar selects (route_a, route_b) and a mute strobe that the datapath uses to zero I/Q samples.

Parameters:
- CODE_W, 8, width of tx/rx switch codes.
- MUTE_CYCLES, 16, number of cycles o_mute is held high per route change (≥1).
- FP_TIMEOUT, 4096, maximum cycles to wait for a frame pulse before forcing the change (≥1).

Ports:
- i_clk_125p  in  1  125 MHz system clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_cfg_valid  in  1  switch request valid
- o_cfg_ready  out  1  controller idle, can accept a request
- i_tx_switch  in  CODE_W  requested tx code (2 = sin, 4 = diff, 6 = both)
- i_rx_switch  in  CODE_W  requested rx code
- i_sin_iqdata_fp  in  1  mother-board frame pulse
- i_diff_iqdata_fp  in  1  daughter-board frame pulse
- o_route_a  out  1  1 = sin outputs take diff inputs
- o_route_b  out  1  1 = diff outputs take sin inputs
- o_mute  out  1  datapath must output zero samples
- o_cfg_done  out  1  one-cycle pulse, request completed
- o_cfg_err  out  1  one-cycle pulse, illegal request rejected
- o_fp_timeout  out  1  sticky: last change was forced by timeout
- o_cur_tx  out  CODE_W  currently applied tx code
- o_cur_rx  out  CODE_W  currently applied rx code

Behaviour:
- Reset (async, any state): state = IDLE; route_a = route_b = 0; o_mute = 0; done = err = 0; o_fp_timeout = 0; o_cur_tx = o_cur_rx = 2; counters = 0.
- Decode table, (tx, rx) → (a, b):
  - (2,2) → 00
  - (2,4) → 01
  - (2,6) → 01
  - (4,2) → 10
  - (4,4) → 00
  - (4,6) → 10
  - (6,6) → 11
  - any other pair is illegal.
- o_cfg_ready = 1 only in IDLE. Accept occurs at an edge where valid & ready; codes are captured at that edge. Valid presented while not ready is ignored and not queued.
- Illegal request: o_cfg_err pulses in the cycle after accept. Route, cur codes and o_fp_timeout are unchanged; state stays IDLE.
- Legal request whose decoded (a, b) equals the current route: o_cfg_done pulses in the cycle after accept; cur codes are updated; no mute; state stays IDLE.
- Legal request with a different route: o_fp_timeout is cleared and the state goes to WAIT_FP in the cycle after accept.
- WAIT_FP:
  - Timeout counter increments every cycle.
  - Exit trigger: (i_sin_iqdata_fp | i_diff_iqdata_fp) sampled high, or counter reaching FP_TIMEOUT-1.
  - On the trigger edge: route_a/b and cur codes update, o_mute goes to 1, mute counter loads MUTE_CYCLES-1, state → MUTE.
  - If the timeout fired and no fp was present on that edge, o_fp_timeout is set.
  - An fp pulse present on the acceptance edge itself is not counted.
- MUTE:
  - o_mute stays high for exactly MUTE_CYCLES cycles; the counter decrements.
  - At the edge where the counter is 0: o_mute → 0, o_cfg_done pulses, state → IDLE (ready is high in the same cycle as done).
- Latency for a route change = 1 (accept) + fp wait + MUTE_CYCLES.
- Simultaneous events: fp arriving in the same cycle as timeout counts as an fp (timeout flag not set). Both fp inputs high together is treated as a single trigger.
- Reset mid-WAIT_FP or mid-MUTE: immediate return to reset values. The route reverts to 00 and mute drops asynchronously.
- Counter widths: $clog2(FP_TIMEOUT), $clog2(MUTE_CYCLES) (minimum 1). Counters saturate and never wrap.

Decomposition:
- Package chsw_pkg holds:
  - state enum {IDLE, WAIT_FP, MUTE}
  - constants CODE_SIN = 2, CODE_DIFF = 4, CODE_BOTH = 6
  - route struct {a, b, legal}
- Sub-module chsw_route_decode: combinational (tx, rx) → {a, b, legal}. Reused by the register-interface checker.

Test Plan:
1. Reset, then idle 10 cycles → route 00, mute 0, ready 1, cur 2/2, no pulses.
2. MUTE_CYCLES = 8; accept (4,2); sin fp 5 cycles later → route becomes 10 on the fp edge; mute high exactly 8 cycles; done pulses once on the cycle mute falls; cur = 4/2.
3. Accept illegal (6,2) → err pulse 1 cycle after accept; route and cur unchanged; ready stays 1; no mute.
4. From route 00 with cur 2/2, accept (4,4) → done 1 cycle after accept; cur = 4/4; no mute; route stays 00.
5. FP_TIMEOUT = 32, no fp; accept (6,6) → route 11 after 32 WAIT_FP cycles; o_fp_timeout = 1; done after mute; next accept clears the flag.
6. During MUTE, hold valid with (2,4) → ignored while ready is 0. Then assert reset mid-MUTE → route 00 and mute 0 asynchronously; after release, ready is 1 and no done pulse appears.

Source files
------------

// File: rtl/chsw_pkg.sv
// Shared types and constants for the IQ channel crossbar switch controller.
package chsw_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FP = 2'd1,
        MUTE    = 2'd2
    } chsw_state_e;

    // Switch codes understood by the crossbar
    localparam int unsigned CODE_SIN  = 2;
    localparam int unsigned CODE_DIFF = 4;
    localparam int unsigned CODE_BOTH = 6;

    // Decoded crossbar selects plus legality of the (tx, rx) pair
    typedef struct packed {
        logic a;
        logic b;
        logic legal;
    } chsw_route_t;

    // Counter width for a count of n values, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chsw_route_decode.sv
// Combinational (tx, rx) switch-code pair to crossbar select decode.
module chsw_route_decode
    import chsw_pkg::*;
#(
    parameter int unsigned CODE_W = 8
) (
    input  logic [CODE_W-1:0] tx_code,
    input  logic [CODE_W-1:0] rx_code,
    output chsw_route_t       route
);

    localparam logic [CODE_W-1:0] C_SIN  = CODE_W'(CODE_SIN);
    localparam logic [CODE_W-1:0] C_DIFF = CODE_W'(CODE_DIFF);
    localparam logic [CODE_W-1:0] C_BOTH = CODE_W'(CODE_BOTH);

    // Table lookup; anything not listed stays illegal with selects low
    always_comb begin
        route = '0;
        if (tx_code == C_SIN) begin
            if (rx_code == C_SIN)       route = '{a: 1'b0, b: 1'b0, legal: 1'b1};
            else if (rx_code == C_DIFF) route = '{a: 1'b0, b: 1'b1, legal: 1'b1};
            else if (rx_code == C_BOTH) route = '{a: 1'b0, b: 1'b1, legal: 1'b1};
        end else if (tx_code == C_DIFF) begin
            if (rx_code == C_SIN)       route = '{a: 1'b1, b: 1'b0, legal: 1'b1};
            else if (rx_code == C_DIFF) route = '{a: 1'b0, b: 1'b0, legal: 1'b1};
            else if (rx_code == C_BOTH) route = '{a: 1'b1, b: 1'b0, legal: 1'b1};
        end else if (tx_code == C_BOTH) begin
            if (rx_code == C_BOTH)      route = '{a: 1'b1, b: 1'b1, legal: 1'b1};
        end
    end

endmodule

// File: rtl/channel_switch_ctrl.sv
// Sequencing controller for the sin/diff IQ crossbar: validates switch
// requests, applies route changes on a frame boundary and mutes around them.
module channel_switch_ctrl
    import chsw_pkg::*;
#(
    parameter int unsigned CODE_W      = 8,
    parameter int unsigned MUTE_CYCLES = 16,
    parameter int unsigned FP_TIMEOUT  = 4096
) (
    input  logic              i_clk_125p,
    input  logic              i_rst_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CODE_W-1:0] i_tx_switch,
    input  logic [CODE_W-1:0] i_rx_switch,
    input  logic              i_sin_iqdata_fp,
    input  logic              i_diff_iqdata_fp,
    output logic              o_route_a,
    output logic              o_route_b,
    output logic              o_mute,
    output logic              o_cfg_done,
    output logic              o_cfg_err,
    output logic              o_fp_timeout,
    output logic [CODE_W-1:0] o_cur_tx,
    output logic [CODE_W-1:0] o_cur_rx
);

    localparam int unsigned TMO_W  = cnt_width(FP_TIMEOUT);
    localparam int unsigned MUTE_W = cnt_width(MUTE_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(FP_TIMEOUT - 1);
    localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_RST  = CODE_W'(CODE_SIN);

    chsw_state_e       state_q, state_d;
    logic              route_a_q, route_a_d, route_b_q, route_b_d;
    logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic              mute_q, mute_d, done_q, done_d, err_q, err_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic [CODE_W-1:0] cur_tx_q, cur_tx_d, cur_rx_q, cur_rx_d;
    logic [CODE_W-1:0] req_tx_q, req_tx_d, req_rx_q, req_rx_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [MUTE_W-1:0] mute_cnt_q, mute_cnt_d;

    chsw_route_t req_route;
    logic        fp_any;
    logic        tmo_hit;

    chsw_route_decode #(
        .CODE_W (CODE_W)
    ) u_route_decode (
        .tx_code (i_tx_switch),
        .rx_code (i_rx_switch),
        .route   (req_route)
    );

    assign fp_any  = i_sin_iqdata_fp | i_diff_iqdata_fp;
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    // Next-state logic for the request / frame-wait / mute sequence
    always_comb begin
        state_d    = state_q;
        route_a_d  = route_a_q;
        route_b_d  = route_b_q;
        pend_a_d   = pend_a_q;
        pend_b_d   = pend_b_q;
        mute_d     = mute_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tmo_flag_d = tmo_flag_q;
        cur_tx_d   = cur_tx_q;
        cur_rx_d   = cur_rx_q;
        req_tx_d   = req_tx_q;
        req_rx_d   = req_rx_q;
        tmo_cnt_d  = tmo_cnt_q;
        mute_cnt_d = mute_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_cfg_valid) begin
                    if (!req_route.legal) begin
                        err_d = 1'b1;
                    end else if (req_route.a == route_a_q && req_route.b == route_b_q) begin
                        // Same crossbar setting: just record the new codes
                        done_d   = 1'b1;
                        cur_tx_d = i_tx_switch;
                        cur_rx_d = i_rx_switch;
                    end else begin
                        tmo_flag_d = 1'b0;
                        pend_a_d   = req_route.a;
                        pend_b_d   = req_route.b;
                        req_tx_d   = i_tx_switch;
                        req_rx_d   = i_rx_switch;
                        tmo_cnt_d  = '0;
                        state_d    = WAIT_FP;
                    end
                end
            end
            WAIT_FP: begin
                if (fp_any || tmo_hit) begin
                    route_a_d  = pend_a_q;
                    route_b_d  = pend_b_q;
                    cur_tx_d   = req_tx_q;
                    cur_rx_d   = req_rx_q;
                    mute_d     = 1'b1;
                    mute_cnt_d = MUTE_LOAD;
                    state_d    = MUTE;
                    // A frame pulse coinciding with the timeout wins
                    if (!fp_any) tmo_flag_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            MUTE: begin
                if (mute_cnt_q == '0) begin
                    mute_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    mute_cnt_d = mute_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, all cleared asynchronously
    always_ff @(posedge i_clk_125p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            route_a_q  <= 1'b0;
            route_b_q  <= 1'b0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            mute_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_flag_q <= 1'b0;
            cur_tx_q   <= CODE_RST;
            cur_rx_q   <= CODE_RST;
            req_tx_q   <= CODE_RST;
            req_rx_q   <= CODE_RST;
            tmo_cnt_q  <= '0;
            mute_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            route_a_q  <= route_a_d;
            route_b_q  <= route_b_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            mute_q     <= mute_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_flag_q <= tmo_flag_d;
            cur_tx_q   <= cur_tx_d;
            cur_rx_q   <= cur_rx_d;
            req_tx_q   <= req_tx_d;
            req_rx_q   <= req_rx_d;
            tmo_cnt_q  <= tmo_cnt_d;
            mute_cnt_q <= mute_cnt_d;
        end
    end

    assign o_cfg_ready  = (state_q == IDLE);
    assign o_route_a    = route_a_q;
    assign o_route_b    = route_b_q;
    assign o_mute       = mute_q;
    assign o_cfg_done   = done_q;
    assign o_cfg_err    = err_q;
    assign o_fp_timeout = tmo_flag_q;
    assign o_cur_tx     = cur_tx_q;
    assign o_cur_rx     = cur_rx_q;

endmodule
